// File: rtl/jump_lut_bank.sv
// Writable multi-bank jump-target table with registered absolute/PC-relative reads.
// After reset, an init sweep clears every entry. Until it finishes, Busy is high and all traffic is ignored.
module jump_lut_bank #(
  parameter int PTR_W  = 4,
  parameter int ADDR_W = 10,
  parameter int BANK_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [BANK_W-1:0] Bank,
  input  logic [PTR_W-1:0]  LutPointer,
  input  logic              RdEn,
  input  logic              Relative,
  input  logic [ADDR_W-1:0] PC,
  input  logic              WrEn,
  input  logic [BANK_W-1:0] WrBank,
  input  logic [PTR_W-1:0]  WrPtr,
  input  logic [ADDR_W-1:0] WrData,
  output logic              Busy,
  output logic [ADDR_W-1:0] AbsAddress,
  output logic              TargetValid,
  output logic              Miss
);

  localparam int IDX_W = BANK_W + PTR_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] abs_q, abs_d;
  logic              tv_q, tv_d;
  logic              miss_q, miss_d;

  // Storage carries no reset; the init sweep clears it.
  logic [ADDR_W-1:0] data_mem  [DEPTH];
  logic              valid_mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_wvalid;

  logic              rd_bypass;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_raw;
  logic [ADDR_W-1:0] rd_sum;

  assign rd_idx = {Bank, LutPointer};
  assign wr_idx = {WrBank, WrPtr};

  // The memory has a single write port, shared by the init sweep and run-time loads.
  always_comb begin
    mem_we     = 1'b0;
    mem_idx    = wr_idx;
    mem_wdata  = WrData;
    mem_wvalid = 1'b1;
    if (state_q == S_INIT) begin
      mem_we     = 1'b1;
      mem_idx    = cnt_q;
      mem_wdata  = '0;
      mem_wvalid = 1'b0;
    end else if (WrEn) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      data_mem[mem_idx]  <= mem_wdata;
      valid_mem[mem_idx] <= mem_wvalid;
    end
  end

  // A write to the index being read in the same cycle is forwarded (write-first).
  always_comb begin
    rd_bypass = WrEn && (wr_idx == rd_idx);
    rd_valid  = rd_bypass || valid_mem[rd_idx];
    rd_raw    = '0;
    if (rd_bypass) begin
      rd_raw = WrData;
    end else if (valid_mem[rd_idx]) begin
      rd_raw = data_mem[rd_idx];
    end
    rd_sum = PC + rd_raw;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tv_d    = 1'b0;
    abs_d   = abs_q;
    miss_d  = miss_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (RdEn) begin
          tv_d   = 1'b1;
          miss_d = !rd_valid;
          if (!rd_valid) begin
            abs_d = '0;
          end else if (Relative) begin
            abs_d = rd_sum;
          end else begin
            abs_d = rd_raw;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      abs_q   <= '0;
      tv_q    <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abs_q   <= abs_d;
      tv_q    <= tv_d;
      miss_q  <= miss_d;
    end
  end

  assign Busy        = (state_q == S_INIT);
  assign AbsAddress  = abs_q;
  assign TargetValid = tv_q;
  assign Miss        = miss_q;

endmodule

// File: tb/tb_jump_lut_bank.sv
// Bench for jump_lut_bank: directed scenarios plus random traffic.
// Everything is checked against a table-level reference model.
module tb_jump_lut_bank;
  localparam int PTR_W  = 4;
  localparam int ADDR_W = 10;
  localparam int BANK_W = 2;
  localparam int DEPTH  = 1 << (BANK_W + PTR_W);

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [BANK_W-1:0] Bank = '0;
  logic [PTR_W-1:0]  LutPointer = '0;
  logic              RdEn = 1'b0;
  logic              Relative = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic              WrEn = 1'b0;
  logic [BANK_W-1:0] WrBank = '0;
  logic [PTR_W-1:0]  WrPtr = '0;
  logic [ADDR_W-1:0] WrData = '0;
  logic              Busy;
  logic [ADDR_W-1:0] AbsAddress;
  logic              TargetValid;
  logic              Miss;

  int total = 0;
  int bad = 0;

  // Reference model: contents, remaining init cycles, last outputs.
  int        m_data  [DEPTH];
  bit        m_valid [DEPTH];
  int        m_left;
  int        m_abs;
  bit        m_tv;
  bit        m_miss;

  jump_lut_bank #(.PTR_W(PTR_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .Clk(Clk), .Reset(Reset), .Bank(Bank), .LutPointer(LutPointer), .RdEn(RdEn),
    .Relative(Relative), .PC(PC), .WrEn(WrEn), .WrBank(WrBank), .WrPtr(WrPtr),
    .WrData(WrData), .Busy(Busy), .AbsAddress(AbsAddress), .TargetValid(TargetValid),
    .Miss(Miss)
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_data[i]  = 0;
    end
    m_left = DEPTH;
    m_abs  = 0;
    m_tv   = 0;
    m_miss = 0;
  endfunction

  // Writes land before the read is evaluated, which gives write-first behaviour.
  task automatic tick();
    int idx;
    @(posedge Clk);
    #1;
    if (!Reset) begin
      if (m_left > 0) begin
        m_left--;
        m_tv = 0;
      end else begin
        if (WrEn) begin
          m_data[int'({WrBank, WrPtr})]  = int'(WrData);
          m_valid[int'({WrBank, WrPtr})] = 1;
        end
        m_tv = RdEn;
        if (RdEn) begin
          idx    = int'({Bank, LutPointer});
          m_miss = !m_valid[idx];
          if (m_miss)        m_abs = 0;
          else if (Relative) m_abs = (int'(PC) + m_data[idx]) % (1 << ADDR_W);
          else               m_abs = m_data[idx];
        end
      end
    end
  endtask

  task automatic idle();
    RdEn = 0; WrEn = 0;
  endtask

  task automatic set_wr(input int b, input int p, input int d);
    WrEn = 1; WrBank = BANK_W'(b); WrPtr = PTR_W'(p); WrData = ADDR_W'(d);
  endtask

  task automatic set_rd(input int b, input int p, input bit rel, input int pc);
    RdEn = 1; Bank = BANK_W'(b); LutPointer = PTR_W'(p); Relative = rel; PC = ADDR_W'(pc);
  endtask

  task automatic assert_reset(input string name);
    Reset = 1;
    #1;
    model_reset();
    total++;
    if ({Busy, TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}}) begin
      bad++;
      $display("FAIL %s got busy=%b tv=%b miss=%b abs=%0d want busy=1 tv=0 miss=0 abs=0",
               name, Busy, TargetValid, Miss, AbsAddress);
    end
  endtask

  // Counts rising edges from the release of reset until Busy falls; TargetValid must stay low throughout.
  task automatic release_and_sweep(input string name, input bit rd_during);
    int edges;
    Reset = 0;
    edges = 0;
    do begin
      if (rd_during) set_rd($urandom_range(3), $urandom_range(15), 0, 0);
      else idle();
      if ($urandom_range(1) == 1) set_wr($urandom_range(3), $urandom_range(15), $urandom_range(1023));
      tick();
      edges++;
      total++;
      if (TargetValid !== 1'b0) begin
        bad++;
        $display("FAIL %s_tv_in_init edge=%0d got tv=%b want 0", name, edges, TargetValid);
      end
    end while (Busy === 1'b1 && edges < 200);
    total++;
    if (edges !== DEPTH || Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_len got %0d edges (busy=%b) want %0d", name, edges, Busy, DEPTH);
    end
    idle();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({Busy, TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_state got busy=%b tv=%b miss=%b abs=%0d want 1/0/0/0",
               Busy, TargetValid, Miss, AbsAddress);
    end
    model_reset();
    repeat (2) tick();
    $display("reset: busy=%b abs=%0d", Busy, AbsAddress);
  endtask

  task automatic test_init_sweep();
    release_and_sweep("init", 1);
    set_rd(1, 7, 0, 0);
    tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b1, {ADDR_W{1'b0}}}) begin
      bad++;
      $display("FAIL first_run_read got tv=%b miss=%b abs=%0d want 1/1/0", TargetValid, Miss, AbsAddress);
    end
    idle();
    $display("init_sweep: first run read tv=%b miss=%b", TargetValid, Miss);
  endtask

  task automatic test_abs_read();
    set_wr(0, 0, 13); tick();
    set_wr(1, 0, 500); tick();
    idle();
    set_rd(0, 0, 0, 0); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd13}) begin
      bad++;
      $display("FAIL abs_read_b0 got tv=%b miss=%b abs=%0d want 1/0/13", TargetValid, Miss, AbsAddress);
    end
    set_rd(1, 0, 0, 0); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd500}) begin
      bad++;
      $display("FAIL abs_read_b1 got tv=%b miss=%b abs=%0d want 1/0/500", TargetValid, Miss, AbsAddress);
    end
    idle(); tick();
    total++;
    if ({TargetValid, AbsAddress} !== {1'b0, 10'd500}) begin
      bad++;
      $display("FAIL abs_pulse got tv=%b abs=%0d want 0/500", TargetValid, AbsAddress);
    end
    $display("abs_read: last abs=%0d", AbsAddress);
  endtask

  task automatic test_miss_hold();
    set_rd(2, 5, 0, 0); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b1, 10'd0}) begin
      bad++;
      $display("FAIL miss_read got tv=%b miss=%b abs=%0d want 1/1/0", TargetValid, Miss, AbsAddress);
    end
    idle(); Bank = 2'd0; LutPointer = '0; tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b0, 1'b1, 10'd0}) begin
      bad++;
      $display("FAIL miss_hold got tv=%b miss=%b abs=%0d want 0/1/0", TargetValid, Miss, AbsAddress);
    end
    $display("miss_hold: miss=%b abs=%0d", Miss, AbsAddress);
  endtask

  task automatic test_relative();
    set_wr(0, 1, 'h3FC); tick();
    set_wr(0, 2, 30); tick();
    idle();
    set_rd(0, 1, 1, 100); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd96}) begin
      bad++;
      $display("FAIL rel_neg got tv=%b miss=%b abs=%0d want 1/0/96", TargetValid, Miss, AbsAddress);
    end
    set_rd(0, 2, 1, 1010); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd16}) begin
      bad++;
      $display("FAIL rel_wrap got tv=%b miss=%b abs=%0d want 1/0/16", TargetValid, Miss, AbsAddress);
    end
    set_rd(3, 9, 1, 700); tick();
    total++;
    if ({Miss, AbsAddress} !== {1'b1, 10'd0}) begin
      bad++;
      $display("FAIL rel_miss got miss=%b abs=%0d want 1/0", Miss, AbsAddress);
    end
    idle();
    $display("relative: abs=%0d", AbsAddress);
  endtask

  task automatic test_bypass();
    set_wr(3, 3, 77); set_rd(3, 3, 0, 0); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd77}) begin
      bad++;
      $display("FAIL bypass got tv=%b miss=%b abs=%0d want 1/0/77", TargetValid, Miss, AbsAddress);
    end
    WrEn = 0; tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b0, 10'd77}) begin
      bad++;
      $display("FAIL bypass_after got tv=%b miss=%b abs=%0d want 1/0/77", TargetValid, Miss, AbsAddress);
    end
    idle();
    $display("bypass: abs=%0d", AbsAddress);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2) != 0) set_wr($urandom_range(3), $urandom_range(3), $urandom_range(1023));
      else WrEn = 0;
      if ($urandom_range(3) != 0) set_rd($urandom_range(3), $urandom_range(3), 1'($urandom_range(1)), $urandom_range(1023));
      else RdEn = 0;
      tick();
      total++;
      if ({Busy, TargetValid, Miss, AbsAddress} !== {1'b0, m_tv, m_miss, ADDR_W'(m_abs)}) begin
        bad++;
        $display("FAIL random n=%0d got busy=%b tv=%b miss=%b abs=%0d want 0/%b/%b/%0d",
                 n, Busy, TargetValid, Miss, AbsAddress, m_tv, m_miss, m_abs);
      end
    end
    idle();
    $display("back_to_back: 400 random cycles");
  endtask

  task automatic test_reset_mid();
    set_wr(0, 0, 111); tick();
    set_wr(2, 9, 222); tick();
    idle();
    assert_reset("reset_mid_run");
    tick(); tick();
    Reset = 0;
    for (int i = 0; i < 20; i++) tick();
    assert_reset("reset_mid_init");
    tick(); tick();
    release_and_sweep("reinit", 0);
    set_rd(0, 0, 0, 0); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b1, 10'd0}) begin
      bad++;
      $display("FAIL lost_b0p0 got tv=%b miss=%b abs=%0d want 1/1/0", TargetValid, Miss, AbsAddress);
    end
    set_rd(2, 9, 1, 300); tick();
    total++;
    if ({TargetValid, Miss, AbsAddress} !== {1'b1, 1'b1, 10'd0}) begin
      bad++;
      $display("FAIL lost_b2p9 got tv=%b miss=%b abs=%0d want 1/1/0", TargetValid, Miss, AbsAddress);
    end
    idle();
    $display("reset_mid: miss=%b abs=%0d", Miss, AbsAddress);
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_abs_read();
    test_miss_hold();
    test_relative();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jump_lut_bank.md
Name: jump_lut_bank

Overview:
- Writable, multi-bank jump-target table that replaces the fixed combinational pointer-to-address LUT in the branch path.
- Each program owns one bank of 2^PTR_W entries. Entries are loaded at run time through a write port.
- Reads have registered, 1-cycle latency. Each read produces either an absolute target or a PC-relative target.
- Sits between the decoder (pointer and bank) and the PC-next mux (AbsAddress).

Parameters:
- PTR_W, 4: LUT pointer width; entries per bank = 2^PTR_W.
- ADDR_W, 10: instruction address width; also the width of each table entry.
- BANK_W, 2: bank select width; number of banks = 2^BANK_W.

Ports:
- Clk, in, 1: clock; all state updates on rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Bank, in, BANK_W: read bank (program) select.
- LutPointer, in, PTR_W: read entry index.
- RdEn, in, 1: read request, sampled on Clk.
- Relative, in, 1: 0 = entry is the absolute target; 1 = entry is a signed offset added to PC.
- PC, in, ADDR_W: current PC; used only when Relative=1.
- WrEn, in, 1: write request.
- WrBank, in, BANK_W: write bank.
- WrPtr, in, PTR_W: write entry index.
- WrData, in, ADDR_W: write data.
- Busy, out, 1: high while the init sweep runs; reads and writes are ignored.
- AbsAddress, out, ADDR_W: registered jump target.
- TargetValid, out, 1: one-cycle pulse marking AbsAddress as a fresh read result.
- Miss, out, 1: registered with AbsAddress; 1 = the entry read has not been written since reset.

Behaviour:
- Storage:
  - 2^(BANK_W+PTR_W) entries of ADDR_W data plus 1 valid bit each.
  - Flat index = {bank, ptr}.
  - Data and valid arrays have no reset; the init sweep clears them.
- Reset asserted (async):
  - Outputs immediately: Busy=1, AbsAddress=0, TargetValid=0, Miss=0.
  - FSM goes to INIT; init counter = 0.
  - Reset mid-sweep or mid-operation restarts the full sweep. Prior contents are lost.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes data=0, valid=0 at index counter, then counter+1.
  - When the last index (2^(BANK_W+PTR_W)-1) is cleared, go to RUN. Busy falls on that edge.
  - Busy is therefore high for exactly 2^(BANK_W+PTR_W) rising edges after Reset deasserts (default 64).
  - RdEn and WrEn are ignored in INIT; TargetValid stays 0.
- RUN writes: WrEn=1 at an edge stores WrData at {WrBank,WrPtr} and sets valid=1. Rewriting an entry overwrites it.
- RUN reads: RdEn=1 at edge N updates the outputs at edge N:
  - TargetValid=1 for that cycle only.
  - Miss = NOT valid[{Bank,LutPointer}].
  - Raw = entry data; 0 if Miss.
  - AbsAddress = Raw if Relative=0.
  - AbsAddress = (PC + Raw) mod 2^ADDR_W if Relative=1. Raw is two's complement, so the sum wraps.
  - A Miss forces AbsAddress=0 regardless of Relative.
- RdEn=0 at an edge: TargetValid=0; AbsAddress and Miss hold their last values.
- Read and write of the same index at the same edge: write-first bypass. The read returns WrData with Miss=0.
- Read and write of different indices at the same edge proceed independently.
- Bank, LutPointer, Relative and PC are sampled only when RdEn=1.
- Out-of-range values cannot occur, because all index bits are fully decoded.

Test Plan:
1. Release Reset; drive RdEn=1 every cycle -> Busy=1 for exactly 64 edges, then 0. TargetValid=0 throughout INIT, and 1 on the first RUN edge with Miss=1, AbsAddress=0.
2. Write bank0/ptr0=13 and bank1/ptr0=500, then read each with Relative=0 -> AbsAddress 13 then 500, Miss=0, TargetValid pulsed once per read.
3. Read never-written bank2/ptr5 -> AbsAddress=0, Miss=1, TargetValid=1. The next cycle with RdEn=0 -> TargetValid=0, AbsAddress held at 0.
4. Relative mode:
   - Bank0/ptr1=0x3FC (-4), PC=100 -> AbsAddress=96.
   - Bank0/ptr2=30, PC=1010 -> AbsAddress=16 (wrap).
5. Same edge WrEn to bank3/ptr3 with 77 and RdEn of bank3/ptr3 -> AbsAddress=77, Miss=0. A subsequent read also returns 77.
6. Load several entries, then assert Reset for 2 cycles mid-RUN and again at init cycle 20 -> outputs zero immediately, a full 64-cycle Busy follows the last release, and prior entries read Miss=1.
